// File: rtl/clt_gauss_gen_pkg.sv
// Shared definitions for the central-limit Gaussian generator.
package clt_gauss_gen_pkg;

    // Defaults matching the Tausworthe URNG feeding this block.
    localparam int URNG_W_DEF = 32;
    localparam int LOG2N_DEF  = 2;

    // Accumulation phase, derived from the sample counter rather than stored.
    typedef enum logic {
        PH_ACCUM = 1'b0,   // still collecting samples 1..N_SUM-1
        PH_LAST  = 1'b1    // next accepted sample completes the sum
    } phase_e;

    // Counter width; a single-sample configuration still needs one bit.
    function automatic int cnt_width(input int log2n);
        return (log2n < 1) ? 1 : log2n;
    endfunction

endpackage

// File: rtl/clt_gauss_gen.sv
// Sums N_SUM uniform words and re-centres the total to a zero-mean signed
// sample, giving approximately Gaussian noise. Valid/ready on both sides.
module clt_gauss_gen
    import clt_gauss_gen_pkg::*;
#(
    parameter  int URNG_W = URNG_W_DEF,
    parameter  int LOG2N  = LOG2N_DEF,
    localparam int OUT_W  = URNG_W + LOG2N
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic [URNG_W-1:0] urng_in,
    input  logic              urng_valid,
    output logic              urng_ready,
    output logic [OUT_W-1:0]  gauss_out,
    output logic              gauss_valid,
    input  logic              gauss_ready,
    output logic [15:0]       gauss_count
);

    localparam int               N_SUM    = 1 << LOG2N;
    localparam int               CNT_W    = cnt_width(LOG2N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SUM - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [15:0]      count_q, count_d;

    phase_e           phase;
    logic             accept;
    logic             complete;
    logic [OUT_W-1:0] sum;

    assign phase = (cnt_q == CNT_LAST) ? PH_LAST : PH_ACCUM;

    // Only the completing sample stalls, and only while the previous result
    // is still held; partial sums keep flowing under backpressure.
    assign urng_ready = !(phase == PH_LAST && valid_q && !gauss_ready);
    assign accept     = urng_valid && urng_ready;
    assign complete   = accept && !clear && (phase == PH_LAST);

    // OUT_W bits hold N_SUM maximal words, so the sum never overflows.
    assign sum = acc_q + OUT_W'(urng_in);

    // Accumulator and sample counter next state; clear discards everything,
    // including a sample accepted in the same cycle.
    always_comb begin
        // NOTE: defaults first so every path assigns each output -- no latches.
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (clear || complete) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Output register: load a completed sum (overriding a same-cycle take so
    // there is no bubble), otherwise drop valid once downstream takes it.
    always_comb begin
        out_d   = out_q;
        valid_d = valid_q;
        count_d = count_q;
        if (complete) begin
            // Flipping the MSB subtracts N_SUM*2^(URNG_W-1): offset-binary to
            // two's complement.
            out_d   = {~sum[OUT_W-1], sum[OUT_W-2:0]};
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
        end else if (gauss_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign gauss_out   = out_q;
    assign gauss_valid = valid_q;
    assign gauss_count = count_q;

endmodule

// File: tb/tb_clt_gauss_gen.sv
// Scoreboard bench for clt_gauss_gen: a driver predicts results from a
// sample-group model; a separate monitor compares whatever the DUT presents.
module tb_clt_gauss_gen;

    localparam int URNG_W = 32;
    localparam int LOG2N  = 2;
    localparam int OUT_W  = URNG_W + LOG2N;
    localparam int N_SUM  = 1 << LOG2N;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              clear = 1'b0;
    logic [URNG_W-1:0] urng_in = '0;
    logic              urng_valid = 1'b0;
    logic              gauss_ready = 1'b0;
    logic              urng_ready;
    logic [OUT_W-1:0]  gauss_out;
    logic              gauss_valid;
    logic [15:0]       gauss_count;

    always #5 clk = ~clk;

    clt_gauss_gen #(.URNG_W(URNG_W), .LOG2N(LOG2N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .urng_in     (urng_in),
        .urng_valid  (urng_valid),
        .urng_ready  (urng_ready),
        .gauss_out   (gauss_out),
        .gauss_valid (gauss_valid),
        .gauss_ready (gauss_ready),
        .gauss_count (gauss_count)
    );

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [15:0]      count;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] group[$];
    bit          m_valid = 1'b0;
    logic [15:0] m_count = '0;
    bit          exp_valid_now = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic: sum of the group minus N_SUM * 2^(URNG_W-1).
    function automatic logic [OUT_W-1:0] model_result();
        longint s = 0;
        foreach (group[i]) s += {32'd0, group[i]};
        s -= longint'(N_SUM) * (longint'(1) << (URNG_W - 1));
        return s[OUT_W-1:0];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        urng_valid = 1'b0;
        clear = 1'b0;
        gauss_ready = 1'b0;
        group.delete();
        sb.delete();
        m_valid = 1'b0;
        exp_valid_now = 1'b0;
        m_count = '0;
        #1;
        check("rst_gauss_valid", gauss_valid, 0);
        check("rst_gauss_out", gauss_out, 0);
        check("rst_gauss_count", gauss_count, 0);
        check("rst_urng_ready", urng_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One clock of stimulus plus the reference-model update for that clock.
    task automatic cycle(input bit v, input logic [31:0] d, input bit clr, input bit gr);
        bit exp_ready, take, acc, done;
        @(negedge clk);
        exp_valid_now = m_valid;
        urng_valid = v;
        urng_in = d;
        clear = clr;
        gauss_ready = gr;
        #1;
        exp_ready = !(group.size() == N_SUM - 1 && m_valid && !gr);
        check("urng_ready", urng_ready, exp_ready);
        take = m_valid && gr;
        acc  = v && exp_ready;
        done = 1'b0;
        if (clr) begin
            group.delete();
        end else if (acc) begin
            group.push_back(d);
            if (group.size() == N_SUM) begin
                exp_t e;
                m_count++;
                e.data = model_result();
                e.count = m_count;
                sb.push_back(e);
                group.delete();
                m_valid = 1'b1;
                done = 1'b1;
            end
        end
        if (!done && take) m_valid = 1'b0;
    endtask

    // Monitor: compare the presented output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                check("gauss_valid", gauss_valid, exp_valid_now);
                if (gauss_valid && exp_valid_now) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_empty: got output %0h expected none", gauss_out);
                    end else begin
                        check("gauss_out", gauss_out, sb[0].data);
                        check("gauss_count", gauss_count, sb[0].count);
                        if (gauss_ready) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // Mid-scale samples sum to exactly zero; valid one clock later.
        repeat (N_SUM) cycle(1, 32'h8000_0000, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);

        // Extremes of the output range.
        repeat (N_SUM) cycle(1, 32'hFFFF_FFFF, 0, 1);
        repeat (N_SUM) cycle(1, 32'h0000_0000, 0, 1);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);

        // Backpressure: 4th completes, 5-7 accumulate, 8th stalls until take.
        for (int i = 0; i < 7; i++) cycle(1, $urandom, 0, 0);
        begin
            logic [31:0] eighth;
            eighth = $urandom;
            cycle(1, eighth, 0, 0);
            cycle(1, eighth, 0, 1);
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);

        // Reset mid-accumulation discards the partial sum.
        repeat (2) cycle(1, $urandom, 0, 1);
        do_reset();
        repeat (N_SUM) cycle(1, 32'h8000_0001, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);

        // Clear after three accepts; also clear coinciding with an accept.
        repeat (3) cycle(1, $urandom, 0, 1);
        cycle(0, 0, 1, 1);
        repeat (N_SUM) cycle(1, 32'h8000_0000, 0, 1);
        repeat (3) cycle(1, $urandom, 0, 1);
        cycle(1, $urandom, 1, 1);
        repeat (N_SUM) cycle(1, 32'h8000_0000, 0, 1);
        cycle(0, 0, 0, 1);

        // Randomised traffic with random valid, ready and occasional clear.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 9))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h0;
                default: d = $urandom;
            endcase
            cycle(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        // Drain and confirm every predicted result was delivered.
        repeat (4) cycle(0, 0, 0, 1);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
